// File: rtl/data_mem_pkg.sv
// Shared types and constants for the byte-lane data memory controller.
package data_mem_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_clr_seq.sv
// Clear sequencer: sweeps zeros across the array one word per cycle after
// reset or on a clear request, then holds IDLE until the next request.
module data_mem_clr_seq
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    output logic              wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a clear request always restarts the sweep at word 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = CLEAR;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_o   = (state_q == CLEAR);
    assign addr_o = cnt_q;
    assign done_o = (state_q == IDLE);

endmodule

// File: rtl/data_mem_ctl.sv
// Byte-lane data memory with zero-sweep clear, registered read data and
// out-of-range error reporting.
module data_mem_ctl
    import data_mem_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [LANES-1:0]          be_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [LANE_W*LANES-1:0]   wdata_i,
    output logic                      ready_o,
    output logic [LANE_W*LANES-1:0]   rdata_o,
    output logic                      rvalid_o,
    output logic                      err_o
);

    localparam int DW    = LANE_W * LANES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, err_q;

    logic              clr_wr_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              done_s;
    logic              acc_s, in_range_s, wr_acc_s, rd_acc_s, err_s;
    logic [IDX_W-1:0]  acc_idx_s, clr_idx_s;

    data_mem_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_i),
        .wr_o   (clr_wr_s),
        .addr_o (clr_addr_s),
        .done_o (done_s)
    );

    assign ready_o    = done_s;
    assign acc_s      = req_i & ready_o;
    // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
    assign in_range_s = ({1'b0, addr_i} < (ADDR_W + 1)'(DEPTH));
    assign wr_acc_s   = acc_s & we_i & in_range_s;
    assign rd_acc_s   = acc_s & ~we_i;
    assign err_s      = acc_s & ~in_range_s & ~(we_i & (be_i == '0));
    assign acc_idx_s  = addr_i[IDX_W-1:0];
    assign clr_idx_s  = clr_addr_s[IDX_W-1:0];

    // Array write port: sweep zeros, or per-lane masked write; never both.
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            mem_q[clr_idx_s] <= '0;
        end else if (wr_acc_s) begin
            for (int k = 0; k < LANES; k++) begin
                if (be_i[k]) begin
                    mem_q[acc_idx_s][k*LANE_W +: LANE_W] <= wdata_i[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read data selection; holds until the next accepted read.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc_s && in_range_s) begin
            rdata_d = mem_q[acc_idx_s];
        end else if (rd_acc_s) begin
            rdata_d = '0;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output registers; reset drops any pending response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rd_acc_s;
            err_q    <= err_s;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_ctl.sv
// Scoreboard bench for data_mem_ctl with LANES=4, ADDR_W=8, DEPTH=200.
module tb_data_mem_ctl;

    localparam int LANES  = 4;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;

    logic        clk;
    logic        rst;
    logic        clr_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;

    typedef struct {
        int          due;
        logic        rv;
        logic        er;
        logic [31:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   n;

    data_mem_ctl #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the expected response when due, otherwise flag any stray pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                tests++;
                if (rvalid_o !== e.rv || err_o !== e.er || (e.rv && rdata_o !== e.d)) begin
                    fails++;
                    $display("FAIL resp@%0d: rvalid=%0b err=%0b rdata=%h, expected rvalid=%0b err=%0b rdata=%h",
                             cyc, rvalid_o, err_o, rdata_o, e.rv, e.er, e.d);
                end
            end else if (rvalid_o || err_o) begin
                tests++;
                fails++;
                $display("FAIL stray_pulse@%0d: rvalid=%0b err=%0b, expected both 0", cyc, rvalid_o, err_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [3:0] be, input logic [7:0] addr,
                       input logic [31:0] wd, input logic clr,
                       input logic xrv, input logic xer, input logic [31:0] xd);
        exp_t x;
        @(negedge clk);
        chk("ready_at_issue", {31'd0, ready_o}, 32'd1);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wd;
        clr_i   = clr;
        if (xrv || xer) begin
            x.due = cyc + 1;
            x.rv  = xrv;
            x.er  = xer;
            x.d   = xd;
            sb_q.push_back(x);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            req_i = 1'b0;
            clr_i = 1'b0;
            we_i  = 1'b0;
        end
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ready_o && cnt < 1000);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; clr_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
        be_i = 4'h0; addr_i = 8'h00; wdata_i = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, ready_o},  32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_err",    {31'd0, err_o},    32'd0);
        chk("rst_rdata",  rdata_o,           32'd0);

        // Full sweep after reset release
        rst = 1'b1;
        wait_ready(n);
        chk("init_sweep_cycles", n, DEPTH);

        acc(1'b0, 4'h0, 8'd199, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd0,   32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(1);

        // Byte-lane merge
        acc(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b1, 4'h5, 8'd5, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd5, 32'h0,        1'b0, 1'b1, 1'b0, 32'hAA22CC44);
        idle(3);
        chk("rdata_hold", rdata_o, 32'hAA22CC44);

        // Read-after-write, then an all-lanes-disabled write
        acc(1'b1, 4'hF, 8'd9, 32'h00000077, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd9, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000077);
        acc(1'b1, 4'h0, 8'd9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd9, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000077);

        // Out-of-range accesses
        acc(1'b1, 4'hF, 8'd210, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0);
        acc(1'b0, 4'h0, 8'd210, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0);
        acc(1'b0, 4'h0, 8'd10,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd9,   32'h0,        1'b0, 1'b1, 1'b0, 32'h00000077);
        acc(1'b0, 4'h0, 8'd200, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0);
        idle(1);

        // Clear with a same-cycle read, requests held during CLEAR, restart mid-sweep
        acc(1'b1, 4'h1, 8'd3, 32'h0000005A, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd3, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000005A);
        acc(1'b0, 4'h0, 8'd3, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000005A);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            clr_i = (n == 50);
        end while (!ready_o && n < 1000);
        req_i = 1'b0;
        clr_i = 1'b0;
        chk("clr_restart_cycles", n, DEPTH + 51);
        acc(1'b0, 4'h0, 8'd3, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd5, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd9, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(1);

        // Restore a nonzero read value, then reset right after a read is accepted
        acc(1'b1, 4'hF, 8'd9, 32'h00000077, 1'b0, 1'b0, 1'b0, 32'h0);
        acc(1'b0, 4'h0, 8'd9, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000077);
        acc(1'b0, 4'h0, 8'd9, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        chk("midread_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("midread_rdata",  rdata_o,           32'd0);
        chk("midread_ready",  {31'd0, ready_o},  32'd0);

        // Reset in the middle of the sweep
        rst = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midsweep_ready", {31'd0, ready_o}, 32'd0);
        rst = 1'b1;
        wait_ready(n);
        chk("resweep_cycles", n, DEPTH);
        acc(1'b0, 4'h0, 8'd9, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
